// File: rtl/rnd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rnd_pkg
// Brief   : Shared types, constants and elaboration-time helpers for rnd_*.
// Revision: 1.0 - initial release
// ============================================================================
package rnd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Default Galois feedback taps shared with rnd_gen (maximal-length polynomials)
  localparam logic [7:0]  c_taps_w8  = 8'hB8;
  localparam logic [15:0] c_taps_w16 = 16'hB400;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Largest multiple of range not exceeding 2**width: draws below it are unbiased
  function automatic longint limit(input int width, input int range);
    longint span;
    span = longint'(1) << width;
    return (span / longint'(range)) * longint'(range);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rnd_range_sampler.sv
`default_nettype none
// ============================================================================
// Module  : rnd_range_sampler
// Brief   : Steps an external LFSR and rejection-samples its state into [0, RANGE).
// Revision: 1.0 - initial release
// ============================================================================
module rnd_range_sampler
  import rnd_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int RANGE     = 6,
  parameter  int MAX_TRIES = 16,
  localparam int OUT_W     = (RANGE > 1) ? clog2(RANGE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             busy,
  input  logic [WIDTH-1:0] rnd_in,
  output logic             rnd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_fail
);

  localparam int               TRIES_W = clog2(MAX_TRIES) + 1;
  localparam logic [WIDTH:0]   LIMIT   = (WIDTH + 1)'(limit(WIDTH, RANGE));
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  state_t               r_state, w_state_nxt;
  logic [TRIES_W-1:0]   r_tries, w_tries_nxt;
  logic [OUT_W-1:0]     r_out_data, w_out_data_nxt;
  logic                 r_out_fail, w_out_fail_nxt;
  logic                 w_accept;
  logic                 w_last_try;
  logic [OUT_W-1:0]     w_mod;

  assign w_accept   = {1'b0, rnd_in} < LIMIT;
  assign w_last_try = (r_tries >= LAST_TRY);
  // Constant modulus; a power-of-two RANGE reduces to the low OUT_W bits
  assign w_mod      = OUT_W'(32'(rnd_in) % 32'(RANGE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tries    <= '0;
      r_out_data <= '0;
      r_out_fail <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tries    <= w_tries_nxt;
      r_out_data <= w_out_data_nxt;
      r_out_fail <= w_out_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tries_nxt    = r_tries;
    w_out_data_nxt = r_out_data;
    w_out_fail_nxt = r_out_fail;
    rnd_en         = 1'b0;
    busy           = 1'b0;
    out_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_state_nxt = STEP;
          w_tries_nxt = '0;
        end
      end
      STEP: begin
        rnd_en      = 1'b1;
        busy        = 1'b1;
        w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (w_accept) begin
          w_out_data_nxt = w_mod;
          w_out_fail_nxt = 1'b0;
          w_state_nxt    = HOLD;
        end else if (w_last_try) begin
          w_out_data_nxt = w_mod;
          w_out_fail_nxt = 1'b1;
          w_state_nxt    = HOLD;
        end else begin
          if (r_tries != '1) w_tries_nxt = r_tries + TRIES_W'(1);
          w_state_nxt = STEP;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // A request coinciding with the transfer starts the next draw immediately
        if (out_ready) begin
          if (req) begin
            w_state_nxt = STEP;
            w_tries_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_data = r_out_data;
  assign out_fail = r_out_fail;

endmodule
`default_nettype wire

// File: tb/tb_rnd_range_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_rnd_range_sampler
// Brief   : Scoreboard bench for rnd_range_sampler with stub and LFSR sources.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rnd_range_sampler;
  import rnd_pkg::*;

  typedef struct packed {
    logic [2:0] data;
    logic       fail;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req, out_ready, req4, ready4;
  logic [7:0] rnd_in, rnd_in4;
  logic       busy, rnd_en, out_valid, out_fail;
  logic [2:0] out_data;
  logic       busy4, rnd_en4, out_valid4, out_fail4;
  logic [2:0] out_data4;

  rnd_range_sampler #(.WIDTH(8), .RANGE(6), .MAX_TRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .rnd_in(rnd_in),
    .rnd_en(rnd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_fail(out_fail)
  );

  rnd_range_sampler #(.WIDTH(8), .RANGE(6), .MAX_TRIES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .busy(busy4), .rnd_in(rnd_in4),
    .rnd_en(rnd_en4), .out_valid(out_valid4), .out_ready(ready4),
    .out_data(out_data4), .out_fail(out_fail4)
  );

  int         cyc = 0, en_cnt = 0, en4_cnt = 0, en_last = -1, xfers = 0;
  int         n_checks = 0, n_fail = 0, lfsr_fails = 0, out_of_range = 0;
  int         hist [6];
  logic [7:0] stub [64];
  logic       use_lfsr = 1'b0;
  logic [7:0] lfsr = 8'h01;
  exp_t       exp_q [$];

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? c_taps_w8 : 8'h00);
  endfunction

  assign rnd_in  = use_lfsr ? lfsr : stub[6'(en_cnt)];
  assign rnd_in4 = 8'd254;
  assign ready4  = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rnd_en) begin
      en_cnt <= en_cnt + 1;
      if (use_lfsr) lfsr <= lfsr_next(lfsr);
    end
    if (rnd_en4) en4_cnt <= en4_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per accepted transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rnd_en) en_last = cyc;
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("result_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e.data));
          check("out_fail", int'(out_fail), int'(e.fail));
        end
        if (use_lfsr) begin
          if (out_fail) lfsr_fails++;
          if (out_data < 3'd6) hist[out_data]++;
          else out_of_range++;
        end
      end
    end
  end

  task automatic pulse_req(output int c0);
    @(posedge clk); #1;
    req = 1'b1;
    c0  = cyc;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic run_basic(input string tag);
    int c0, vc, e0, base;
    base = en_cnt;
    for (int i = 0; i < 4; i++) stub[6'(base + i)] = 8'd17;
    e0 = en_cnt;
    exp_q.push_back(exp_t'{data: 3'd5, fail: 1'b0});
    pulse_req(c0);
    wait_valid(vc);
    check({tag, "_latency"}, vc - c0, 3);
    check({tag, "_en_cycle"}, en_last - c0, 1);
    check({tag, "_en_pulses"}, en_cnt - e0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, vc, vc2, e0, base, x0, t;
    logic [7:0] pred;
    exp_t e;
    for (int i = 0; i < 64; i++) stub[i] = 8'd0;
    for (int i = 0; i < 6; i++) hist[i] = 0;
    rst_n = 1'b0; req = 1'b0; req4 = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({busy, rnd_en, out_valid, out_data, out_fail}), 0);
    check("reset_outputs4", int'({busy4, rnd_en4, out_valid4, out_data4, out_fail4}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_step", en_cnt, 0);

    run_basic("basic");

    // Two biased draws then an accepted one
    base = en_cnt;
    stub[6'(base + 1)] = 8'd253;
    stub[6'(base + 2)] = 8'd255;
    stub[6'(base + 3)] = 8'd40;
    e0 = en_cnt;
    exp_q.push_back(exp_t'{data: 3'd4, fail: 1'b0});
    pulse_req(c0);
    wait_valid(vc);
    check("reject_latency", vc - c0, 7);
    check("reject_en_pulses", en_cnt - e0, 3);

    // Fallback after MAX_TRIES=4 rejections
    e0 = en4_cnt;
    @(posedge clk); #1; req4 = 1'b1; c0 = cyc;
    @(posedge clk); #1; req4 = 1'b0;
    vc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid4) begin vc = cyc; break; end
    end
    check("fallback_latency", vc - c0, 9);
    check("fallback_en_pulses", en4_cnt - e0, 4);
    check("fallback_data", int'(out_data4), 2);
    check("fallback_fail", int'(out_fail4), 1);
    repeat (5) @(negedge clk);
    check("fallback_no_5th_step", en4_cnt - e0, 4);
    check("fallback_idle", int'(out_valid4), 0);

    // Backpressure, then a request coinciding with the transfer
    out_ready = 1'b0;
    base = en_cnt;
    stub[6'(base + 1)] = 8'd100;
    stub[6'(base + 2)] = 8'd9;
    exp_q.push_back(exp_t'{data: 3'd4, fail: 1'b0});
    exp_q.push_back(exp_t'{data: 3'd3, fail: 1'b0});
    x0 = xfers;
    pulse_req(c0);
    wait_valid(vc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_stable", int'(out_valid), 1);
      check("bp_data_stable", int'(out_data), 4);
    end
    check("bp_no_xfer", xfers - x0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1; req = 1'b1; t = cyc;
    @(posedge clk); #1;
    req = 1'b0;
    check("bp_one_xfer", xfers - x0, 1);
    wait_valid(vc2);
    check("b2b_en_cycle", en_last - t, 1);
    check("b2b_latency", vc2 - t, 3);

    // Asynchronous reset while in SAMPLE, away from any clock edge
    base = en_cnt;
    stub[6'(base + 1)] = 8'd17;
    pulse_req(c0);
    @(posedge clk); #2;
    check("in_sample", int'({busy, rnd_en}), 2);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({busy, rnd_en, out_valid, out_data, out_fail}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("aborted_no_valid", int'(out_valid), 0);
    run_basic("post_reset");

    // Real Galois LFSR source, 1000 requests predicted by a reference model
    @(negedge clk);
    use_lfsr = 1'b1;
    pred = 8'h01;
    for (int n = 0; n < 1000; n++) begin
      e.fail = 1'b0;
      for (int k = 0; k < 16; k++) begin
        pred   = lfsr_next(pred);
        e.data = 3'(pred % 8'd6);
        if (pred < 8'd252) break;
        if (k == 15) e.fail = 1'b1;
      end
      exp_q.push_back(e);
      pulse_req(c0);
      wait_valid(vc);
      if (vc < 0) break;
    end
    @(negedge clk);
    check("lfsr_no_fail", lfsr_fails, 0);
    check("lfsr_in_range", out_of_range, 0);
    for (int k = 0; k < 6; k++)
      check($sformatf("hist_%0d_within_25pct", k), int'(hist[k] >= 125 && hist[k] <= 207), 1);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
